// File: rtl/register_pkg.sv
// Shared constants for the register-file leaf cell and its bus bundle.
package register_pkg;
  localparam int DEFAULT_W = 8;
endpackage

// File: rtl/register_if.sv
// Write/read data bundle for one register cell; the register file drives wr_dat, reads rd_dat.
interface register_if
  import register_pkg::*;
#(
  parameter int w = DEFAULT_W
);
  logic [w-1:0] wr_dat;
  logic [w-1:0] rd_dat;

  modport master (output wr_dat, input rd_dat);
  modport slave  (input wr_dat, output rd_dat);
endinterface

// File: rtl/register.sv
// Edge-triggered w-bit storage cell, async active-high clear to RESET_VALUE.
// Latency: out follows in one clock-to-q after the rising edge; no backpressure, every edge writes.
module register
  import register_pkg::*;
#(
  parameter int           w           = DEFAULT_W,
  parameter logic [w-1:0] RESET_VALUE = '0
) (
  output logic [w-1:0] out,
  input  logic [w-1:0] in,
  input  logic         clock,
  input  logic         reset
);

  // clock is the register file's per-register write strobe, so there is no enable here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) out <= RESET_VALUE;
    else       out <= in;
  end

endmodule

// File: tb/tb_register.sv
// Directed checks of the register cell at default width and at w=16 / RESET_VALUE=16'hBEEF.
module tb_register;
  import register_pkg::*;

  logic clock;
  logic rst8;
  logic rst16;
  int   n_vec;
  int   n_bad;

  register_if #(.w(8))  bus8 ();
  register_if #(.w(16)) bus16 ();

  register dut8 (
    .out   (bus8.rd_dat),
    .in    (bus8.wr_dat),
    .clock (clock),
    .reset (rst8)
  );

  register #(.w(16), .RESET_VALUE(16'hBEEF)) dut16 (
    .out   (bus16.rd_dat),
    .in    (bus16.wr_dat),
    .clock (clock),
    .reset (rst16)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full strobe: rise, hold, fall, then settle so outputs are sampled away from the edge.
  task automatic pulse();
    #4 clock = 1'b1;
    #5 clock = 1'b0;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Reset at time 0, no clock edges yet
    clock = 1'b0;
    rst16 = 1'b0;
    bus16.wr_dat = 16'h0000;
    rst8  = 1'b1;
    bus8.wr_dat = 8'hA5;
    #1;
    check8("reset_immediate", bus8.rd_dat, 8'h00);
    pulse();
    check8("reset_hold_edge1", bus8.rd_dat, 8'h00);
    pulse();
    check8("reset_hold_edge2", bus8.rd_dat, 8'h00);

    // Basic write, then input change and falling edge must not disturb the value
    rst8 = 1'b0;
    #2;
    bus8.wr_dat = 8'h3C;
    pulse();
    check8("basic_write", bus8.rd_dat, 8'h3C);
    bus8.wr_dat = 8'hFF;
    #2;
    check8("in_change_no_edge", bus8.rd_dat, 8'h3C);
    bus8.wr_dat = 8'h3C;
    #2 clock = 1'b1;
    #2 bus8.wr_dat = 8'hFF;
    #2 clock = 1'b0;
    #1;
    check8("falling_edge_hold", bus8.rd_dat, 8'h3C);

    // Back-to-back writes
    bus8.wr_dat = 8'h01;
    pulse();
    check8("b2b_01", bus8.rd_dat, 8'h01);
    bus8.wr_dat = 8'h80;
    pulse();
    check8("b2b_80", bus8.rd_dat, 8'h80);
    bus8.wr_dat = 8'hFF;
    pulse();
    check8("b2b_ff", bus8.rd_dat, 8'hFF);

    // Asynchronous clear between edges
    bus8.wr_dat = 8'h5A;
    pulse();
    check8("pre_clear_5a", bus8.rd_dat, 8'h5A);
    #2 rst8 = 1'b1;
    #1;
    check8("async_clear", bus8.rd_dat, 8'h00);
    #2 rst8 = 1'b0;
    #1;
    check8("clear_holds_after_release", bus8.rd_dat, 8'h00);
    bus8.wr_dat = 8'h77;
    pulse();
    check8("write_after_clear", bus8.rd_dat, 8'h77);

    // Reset coincident with a rising edge: reset wins
    bus8.wr_dat = 8'hC3;
    #2;
    rst8  = 1'b1;
    clock = 1'b1;
    #1;
    check8("reset_vs_edge", bus8.rd_dat, 8'h00);
    #2 clock = 1'b0;
    #2 rst8 = 1'b0;
    #1;
    check8("reset_vs_edge_release", bus8.rd_dat, 8'h00);

    // Wide instance with non-zero reset value
    bus8.wr_dat = 8'h96;
    rst16 = 1'b1;
    #1;
    check16("w16_reset_value", bus16.rd_dat, 16'hBEEF);
    check8("w8_unaffected_by_rst16", bus8.rd_dat, 8'h00);
    #2 rst16 = 1'b0;
    bus16.wr_dat = 16'h1234;
    pulse();
    check16("w16_write", bus16.rd_dat, 16'h1234);
    check8("w8_shared_strobe", bus8.rd_dat, 8'h96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
